// File: rtl/mem_responder_pkg.sv
// ------------------------------------------------------------------
// mem_responder_pkg : shared types and constants for mem_responder
// Rev 1.0
// ------------------------------------------------------------------
`default_nettype none

package mem_responder_pkg;

  localparam int DEF_ADDR_W = 8;
  localparam int DEF_DATA_W = 16;
  localparam int LAT_MIN    = 1;
  localparam int LAT_MAX    = 15;
  localparam int CNT_W      = 4;

  typedef enum logic [1:0] {
    IDLE   = 2'b00,
    ACCESS = 2'b01,
    RESP   = 2'b10
  } state_e;

endpackage

`default_nettype wire

// File: rtl/mem_responder_sram_1p.sv
// ------------------------------------------------------------------
// sram_1p : single-port synchronous RAM with registered read data
// Rev 1.0
// ------------------------------------------------------------------
`default_nettype none

module sram_1p #(
  parameter int ADDR_W = 8,
  parameter int DATA_W = 16
) (
  input  logic              clk,
  input  logic              we,
  input  logic [ADDR_W-1:0] addr,
  input  logic [DATA_W-1:0] wdata,
  output logic [DATA_W-1:0] rdata
);

  logic [DATA_W-1:0] mem_q [2**ADDR_W];

  // Read-before-write: rdata shows the old word on a write cycle.
  always_ff @(posedge clk) begin
    if (we) begin
      mem_q[addr] <= wdata;
    end
    rdata <= mem_q[addr];
  end

endmodule

`default_nettype wire

// File: rtl/mem_responder.sv
// ------------------------------------------------------------------
// mem_responder : valid/ready memory responder, one transaction in flight
// Rev 1.0
// ------------------------------------------------------------------
`default_nettype none

module mem_responder
  import mem_responder_pkg::*;
#(
  parameter int ADDR_W  = DEF_ADDR_W,
  parameter int DATA_W  = DEF_DATA_W,
  parameter int LATENCY = 2
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              req_valid,
  output logic              req_ready,
  input  logic              req_we,
  input  logic [ADDR_W-1:0] req_addr,
  input  logic [DATA_W-1:0] req_wdata,
  output logic              rsp_valid,
  input  logic              rsp_ready,
  output logic              rsp_we,
  output logic [DATA_W-1:0] rsp_rdata
);

  if (LATENCY < LAT_MIN || LATENCY > LAT_MAX) begin : g_lat_check
    $error("mem_responder: LATENCY must be within 1..15");
  end

  localparam logic [CNT_W-1:0] c_lat_load = CNT_W'(LATENCY - 1);

  state_e              state_q;
  logic [CNT_W-1:0]    cnt_q;
  logic                we_q;
  logic [ADDR_W-1:0]   addr_q;
  logic [DATA_W-1:0]   wdata_q;
  logic                rsp_valid_q;
  logic                rsp_we_q;
  logic [DATA_W-1:0]   rsp_rdata_q;

  logic                ram_we;
  logic [ADDR_W-1:0]   ram_addr;
  logic [DATA_W-1:0]   ram_rdata;
  logic                access_done;

  assign access_done = (state_q == ACCESS) && (cnt_q == '0);

  // Reset gates the strobe so an interrupted write never lands in RAM.
  assign ram_we   = !reset && access_done && we_q;
  // In IDLE the RAM already reads the incoming address, so a
  // one-cycle latency still finds the read word ready at RESP entry.
  assign ram_addr = (state_q == IDLE) ? req_addr : addr_q;

  sram_1p #(
    .ADDR_W (ADDR_W),
    .DATA_W (DATA_W)
  ) u_sram (
    .clk   (clk),
    .we    (ram_we),
    .addr  (ram_addr),
    .wdata (wdata_q),
    .rdata (ram_rdata)
  );

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q     <= IDLE;
      cnt_q       <= '0;
      rsp_valid_q <= 1'b0;
      rsp_we_q    <= 1'b0;
      rsp_rdata_q <= '0;
    end else begin
      case (state_q)
        IDLE: begin
          if (req_valid) begin
            we_q    <= req_we;
            addr_q  <= req_addr;
            wdata_q <= req_wdata;
            cnt_q   <= c_lat_load;
            state_q <= ACCESS;
          end
        end
        ACCESS: begin
          if (cnt_q == '0) begin
            state_q     <= RESP;
            rsp_valid_q <= 1'b1;
            rsp_we_q    <= we_q;
            rsp_rdata_q <= we_q ? wdata_q : ram_rdata;
          end else begin
            cnt_q <= cnt_q - 4'd1;
          end
        end
        RESP: begin
          if (rsp_ready) begin
            state_q     <= IDLE;
            rsp_valid_q <= 1'b0;
          end
        end
        default: begin
          state_q <= IDLE;
        end
      endcase
    end
  end

  assign req_ready = (state_q == IDLE);
  assign rsp_valid = rsp_valid_q;
  assign rsp_we    = rsp_we_q;
  assign rsp_rdata = rsp_rdata_q;

endmodule

`default_nettype wire
